// File: rtl/mm_bus_initiator.sv
// mm_bus_initiator
//   Single-outstanding initiator for the MM register bus. A host command
//   (ready/valid) becomes a one-cycle read or write strobe toward the
//   address decoders. Writes complete immediately. Reads wait for
//   MM_RD_DATA_V, or give up after TIMEOUT cycles and return an error
//   pattern. Every request gets exactly one RSP_V pulse. Two saturating
//   status counters track read timeouts and read-data pulses that do not
//   belong to a pending read.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   REQ_V/REQ_RDY                 request handshake
//   REQ_WR/REQ_ADDR/REQ_WDATA     request payload
//   RSP_V/RSP_WR/RSP_ERR/RSP_DATA one-cycle response (no backpressure)
//   MM_WR_EN/MM_RD_EN             one-cycle strobes to the decoder
//   MM_ADDR/MM_WR_DATA            address and write data to the decoder
//   MM_RD_DATA/MM_RD_DATA_V       read return from the decoder
//   TIMEOUT_CNT/STRAY_CNT         saturating status counters
module mm_bus_initiator #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              REQ_V,
    output logic              REQ_RDY,
    input  logic              REQ_WR,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_V,
    output logic              RSP_WR,
    output logic              RSP_ERR,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              MM_WR_EN,
    output logic              MM_RD_EN,
    output logic [ADDR_W-1:0] MM_ADDR,
    output logic [DATA_W-1:0] MM_WR_DATA,
    input  logic [DATA_W-1:0] MM_RD_DATA,
    input  logic              MM_RD_DATA_V,
    output logic [CNT_W-1:0]  TIMEOUT_CNT,
    output logic [CNT_W-1:0]  STRAY_CNT
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_STB  = 3'd1;
    localparam logic [2:0] ST_RD_STB  = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    logic [2:0]        state_q,       state_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic              req_rdy_q,     req_rdy_d;
    logic              rsp_v_q,       rsp_v_d;
    logic              rsp_wr_q,      rsp_wr_d;
    logic              rsp_err_q,     rsp_err_d;
    logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;
    logic              mm_wr_en_q,    mm_wr_en_d;
    logic              mm_rd_en_q,    mm_rd_en_d;
    logic [ADDR_W-1:0] mm_addr_q,     mm_addr_d;
    logic [DATA_W-1:0] mm_wr_data_q,  mm_wr_data_d;
    logic [CNT_W-1:0]  timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0]  stray_cnt_q,   stray_cnt_d;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // Timeout payload: marker word in the upper half, faulting address below.
    function automatic logic [DATA_W-1:0] err_pattern(input logic [ADDR_W-1:0] a);
        return {32'hDEAD_BEEF, {(DATA_W-32-ADDR_W){1'b0}}, a};
    endfunction

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        req_rdy_d     = 1'b0;
        rsp_v_d       = 1'b0;
        rsp_wr_d      = rsp_wr_q;
        rsp_err_d     = rsp_err_q;
        rsp_data_d    = rsp_data_q;
        mm_wr_en_d    = 1'b0;
        mm_rd_en_d    = 1'b0;
        mm_addr_d     = mm_addr_q;
        mm_wr_data_d  = mm_wr_data_q;
        timeout_cnt_d = timeout_cnt_q;
        stray_cnt_d   = stray_cnt_q;

        // Read data is only meaningful while a read is pending; anything
        // else (late data after a timeout, data during a write) is counted
        // and dropped.
        if (MM_RD_DATA_V && (state_q != ST_RD_WAIT)) begin
            stray_cnt_d = sat_inc(stray_cnt_q);
        end

        case (state_q)
            ST_IDLE: begin
                req_rdy_d = 1'b1;
                if (REQ_V && req_rdy_q) begin
                    req_rdy_d    = 1'b0;
                    mm_addr_d    = REQ_ADDR;
                    mm_wr_data_d = REQ_WDATA;
                    if (REQ_WR) begin
                        mm_wr_en_d = 1'b1;
                        state_d    = ST_WR_STB;
                    end else begin
                        mm_rd_en_d = 1'b1;
                        state_d    = ST_RD_STB;
                    end
                end
            end
            ST_WR_STB: begin
                // Writes are posted: respond right after the strobe.
                rsp_v_d    = 1'b1;
                rsp_wr_d   = 1'b1;
                rsp_err_d  = 1'b0;
                rsp_data_d = '0;
                state_d    = ST_RESP;
            end
            ST_RD_STB: begin
                // Counter holds the number of the wait cycle being observed.
                wait_cnt_d = WAIT_W'(1);
                state_d    = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (MM_RD_DATA_V) begin
                    // Data on the final wait cycle still beats the timeout.
                    rsp_v_d    = 1'b1;
                    rsp_wr_d   = 1'b0;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = MM_RD_DATA;
                    state_d    = ST_RESP;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    rsp_v_d       = 1'b1;
                    rsp_wr_d      = 1'b0;
                    rsp_err_d     = 1'b1;
                    rsp_data_d    = err_pattern(mm_addr_q);
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_RESP: begin
                req_rdy_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= '0;
            req_rdy_q     <= 1'b0;
            rsp_v_q       <= 1'b0;
            rsp_wr_q      <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_data_q    <= '0;
            mm_wr_en_q    <= 1'b0;
            mm_rd_en_q    <= 1'b0;
            mm_addr_q     <= '0;
            mm_wr_data_q  <= '0;
            timeout_cnt_q <= '0;
            stray_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            req_rdy_q     <= req_rdy_d;
            rsp_v_q       <= rsp_v_d;
            rsp_wr_q      <= rsp_wr_d;
            rsp_err_q     <= rsp_err_d;
            rsp_data_q    <= rsp_data_d;
            mm_wr_en_q    <= mm_wr_en_d;
            mm_rd_en_q    <= mm_rd_en_d;
            mm_addr_q     <= mm_addr_d;
            mm_wr_data_q  <= mm_wr_data_d;
            timeout_cnt_q <= timeout_cnt_d;
            stray_cnt_q   <= stray_cnt_d;
        end
    end

    assign REQ_RDY     = req_rdy_q;
    assign RSP_V       = rsp_v_q;
    assign RSP_WR      = rsp_wr_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_DATA    = rsp_data_q;
    assign MM_WR_EN    = mm_wr_en_q;
    assign MM_RD_EN    = mm_rd_en_q;
    assign MM_ADDR     = mm_addr_q;
    assign MM_WR_DATA  = mm_wr_data_q;
    assign TIMEOUT_CNT = timeout_cnt_q;
    assign STRAY_CNT   = stray_cnt_q;

endmodule

// File: tb/tb_mm_bus_initiator.sv
// tb_mm_bus_initiator
//   Transaction-level bench for mm_bus_initiator. Each request is driven
//   with a chosen responder latency; the expected strobe timing, response
//   cycle, response payload and counter values are worked out from the
//   bus rules (latency within TIMEOUT -> data, otherwise error pattern).
module tb_mm_bus_initiator;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        REQ_V;
    logic        REQ_RDY;
    logic        REQ_WR;
    logic [16:0] REQ_ADDR;
    logic [63:0] REQ_WDATA;
    logic        RSP_V;
    logic        RSP_WR;
    logic        RSP_ERR;
    logic [63:0] RSP_DATA;
    logic        MM_WR_EN;
    logic        MM_RD_EN;
    logic [16:0] MM_ADDR;
    logic [63:0] MM_WR_DATA;
    logic [63:0] MM_RD_DATA;
    logic        MM_RD_DATA_V;
    logic [15:0] TIMEOUT_CNT;
    logic [15:0] STRAY_CNT;

    int checks   = 0;
    int failures = 0;
    int exp_to   = 0;
    int exp_st   = 0;

    mm_bus_initiator #(
        .ADDR_W (17),
        .DATA_W (64),
        .TIMEOUT(TO),
        .CNT_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .REQ_V       (REQ_V),
        .REQ_RDY     (REQ_RDY),
        .REQ_WR      (REQ_WR),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_WDATA   (REQ_WDATA),
        .RSP_V       (RSP_V),
        .RSP_WR      (RSP_WR),
        .RSP_ERR     (RSP_ERR),
        .RSP_DATA    (RSP_DATA),
        .MM_WR_EN    (MM_WR_EN),
        .MM_RD_EN    (MM_RD_EN),
        .MM_ADDR     (MM_ADDR),
        .MM_WR_DATA  (MM_WR_DATA),
        .MM_RD_DATA  (MM_RD_DATA),
        .MM_RD_DATA_V(MM_RD_DATA_V),
        .TIMEOUT_CNT (TIMEOUT_CNT),
        .STRAY_CNT   (STRAY_CNT)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic wait_rdy(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!REQ_RDY && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = REQ_RDY;
        if (!ok) chk("req_rdy_wait", 64'(REQ_RDY), 64'd1);
    endtask

    task automatic do_write(input logic [16:0] a, input logic [63:0] d, input bit stray);
        bit ok;
        wait_rdy(ok);
        if (!ok) return;
        REQ_V = 1'b1; REQ_WR = 1'b1; REQ_ADDR = a; REQ_WDATA = d;
        @(negedge clk);
        REQ_V = 1'b0; REQ_ADDR = 17'($urandom); REQ_WDATA = rnd64();
        chk("wr_stb",    64'(MM_WR_EN), 64'd1);
        chk("wr_no_rd",  64'(MM_RD_EN), 64'd0);
        chk("wr_addr",   64'(MM_ADDR),  64'(a));
        chk("wr_data",   MM_WR_DATA,    d);
        chk("wr_busy",   64'(REQ_RDY),  64'd0);
        if (stray) begin
            MM_RD_DATA_V = 1'b1; MM_RD_DATA = rnd64();
        end
        @(negedge clk);
        MM_RD_DATA_V = 1'b0;
        if (stray) exp_st = sat16(exp_st);
        chk("wr_stb_drop", 64'(MM_WR_EN), 64'd0);
        chk("wr_rsp_v",    64'(RSP_V),    64'd1);
        chk("wr_rsp_wr",   64'(RSP_WR),   64'd1);
        chk("wr_rsp_err",  64'(RSP_ERR),  64'd0);
        chk("wr_rsp_data", RSP_DATA,      64'd0);
        chk("wr_stray",    64'(STRAY_CNT), 64'(exp_st));
        @(negedge clk);
        chk("wr_rsp_once", 64'(RSP_V),   64'd0);
        chk("wr_rdy_back", 64'(REQ_RDY), 64'd1);
        chk("wr_addr_hold", 64'(MM_ADDR), 64'(a));
    endtask

    // lat = wait cycle (1..TO) on which read data is returned; 0 = never.
    task automatic do_read(input logic [16:0] a, input logic [63:0] wd, input int lat,
                           input logic [63:0] rd);
        bit ok;
        int last;
        bit good;
        logic [63:0] exp_data;
        wait_rdy(ok);
        if (!ok) return;
        REQ_V = 1'b1; REQ_WR = 1'b0; REQ_ADDR = a; REQ_WDATA = wd;
        @(negedge clk);
        REQ_V = 1'b0; REQ_ADDR = 17'($urandom); REQ_WDATA = rnd64();
        chk("rd_stb",   64'(MM_RD_EN), 64'd1);
        chk("rd_no_wr", 64'(MM_WR_EN), 64'd0);
        chk("rd_addr",  64'(MM_ADDR),  64'(a));
        chk("rd_wdata", MM_WR_DATA,    wd);
        chk("rd_busy",  64'(REQ_RDY),  64'd0);
        good = (lat >= 1 && lat <= TO);
        last = good ? lat : TO;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            chk("rd_wait_stb", 64'(MM_RD_EN), 64'd0);
            chk("rd_wait_rsp", 64'(RSP_V),    64'd0);
            if (k == lat) begin
                MM_RD_DATA_V = 1'b1; MM_RD_DATA = rd;
            end
        end
        @(negedge clk);
        MM_RD_DATA_V = 1'b0; MM_RD_DATA = rnd64();
        if (good) begin
            exp_data = rd;
        end else begin
            exp_data = {32'hDEAD_BEEF, 15'b0, a};
            exp_to   = sat16(exp_to);
        end
        chk("rd_rsp_v",    64'(RSP_V),       64'd1);
        chk("rd_rsp_wr",   64'(RSP_WR),      64'd0);
        chk("rd_rsp_err",  64'(RSP_ERR),     64'(!good));
        chk("rd_rsp_data", RSP_DATA,         exp_data);
        chk("rd_to_cnt",   64'(TIMEOUT_CNT), 64'(exp_to));
        chk("rd_st_cnt",   64'(STRAY_CNT),   64'(exp_st));
        chk("rd_rsp_busy", 64'(REQ_RDY),     64'd0);
        @(negedge clk);
        chk("rd_rsp_once", 64'(RSP_V),    64'd0);
        chk("rd_rdy_back", 64'(REQ_RDY),  64'd1);
        chk("rd_data_hold", RSP_DATA,     exp_data);
        chk("rd_addr_hold", 64'(MM_ADDR), 64'(a));
    endtask

    task automatic stray_pulse();
        @(negedge clk);
        MM_RD_DATA_V = 1'b1; MM_RD_DATA = rnd64();
        @(negedge clk);
        MM_RD_DATA_V = 1'b0;
        exp_st = sat16(exp_st);
        chk("stray_cnt",    64'(STRAY_CNT), 64'(exp_st));
        chk("stray_no_rsp", 64'(RSP_V),     64'd0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_rdy"},   64'(REQ_RDY),     64'd0);
        chk({pfx, "_rsp_v"}, 64'(RSP_V),       64'd0);
        chk({pfx, "_rdata"}, RSP_DATA,         64'd0);
        chk({pfx, "_rerr"},  64'(RSP_ERR),     64'd0);
        chk({pfx, "_wr_en"}, 64'(MM_WR_EN),    64'd0);
        chk({pfx, "_rd_en"}, 64'(MM_RD_EN),    64'd0);
        chk({pfx, "_addr"},  64'(MM_ADDR),     64'd0);
        chk({pfx, "_wdata"}, MM_WR_DATA,       64'd0);
        chk({pfx, "_to"},    64'(TIMEOUT_CNT), 64'd0);
        chk({pfx, "_st"},    64'(STRAY_CNT),   64'd0);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; REQ_V = 1'b0; REQ_WR = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
        MM_RD_DATA = '0; MM_RD_DATA_V = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        #1 chk("rdy_before_edge", 64'(REQ_RDY), 64'd0);
        @(negedge clk);
        chk("rdy_first_edge", 64'(REQ_RDY), 64'd1);

        // Directed cases
        do_write(17'h04010, 64'h0123_4567_89AB_CDEF, 1'b0);
        do_read(17'h00123, 64'h1111_2222_3333_4444, 3, 64'hCAFE);
        do_read(17'h1ABCD, 64'h0, 0, 64'h0);
        stray_pulse();                                    // late data after timeout
        do_write(17'h00008, 64'hFFFF_0000_FFFF_0000, 1'b1); // data during write strobe
        do_read(17'h0F0F0, 64'h5, TO, 64'h8765_4321_0FED_CBA9);
        do_read(17'h00001, 64'h6, 1, 64'hA5A5_A5A5_5A5A_5A5A);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                do_write(17'($urandom), rnd64(), ($urandom_range(0, 3) == 0));
            end else if (kind == 3) begin
                stray_pulse();
            end else begin
                do_read(17'($urandom), rnd64(), $urandom_range(0, TO), rnd64());
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in the middle of a pending read
        wait_rdy(ok);
        if (ok) begin
            REQ_V = 1'b1; REQ_WR = 1'b0; REQ_ADDR = 17'h01234; REQ_WDATA = rnd64();
            @(negedge clk);
            REQ_V = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b0;
            #1 chk_all_zero("mid_rst");
            exp_to = 0; exp_st = 0;
            @(negedge clk);
            rst_n = 1'b1;
            #1 chk("mid_rdy_before_edge", 64'(REQ_RDY), 64'd0);
            @(negedge clk);
            chk("mid_rdy_first_edge", 64'(REQ_RDY), 64'd1);
            chk("mid_no_rsp",         64'(RSP_V),   64'd0);
        end
        do_read(17'h0BEEF, 64'h7, 2, 64'h0000_0000_DEAD_C0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
